// File: rtl/seq_mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter must hold the value WIDTH itself, hence the extra bit.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/adder_nbit.sv
// Parametrised ripple-carry adder used for the multiplier accumulate step.
module adder_nbit #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry_s;

    // Bit-serial carry propagation from LSB to MSB.
    always_comb begin
        carry_s[0] = cin;
        for (int i = 0; i < N; i++) begin
            sum[i]         = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i + 1] = (a[i] & b[i]) | (a[i] & carry_s[i]) | (b[i] & carry_s[i]);
        end
    end

    assign cout = carry_s[N];

endmodule

// File: rtl/seq_multiplier.sv
// Sequential signed/unsigned multiplier: magnitudes are multiplied one bit per
// cycle with a right-shifting product register, then the sign is re-applied.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] y
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]    ONE_P    = {{(PW-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    function automatic logic [PW-1:0] negate_p(input logic [PW-1:0] v);
        return ~v + ONE_P;
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic [WIDTH-1:0]  mag_a_r;
    logic [PW-1:0]     prod_r;
    logic              neg_r;
    logic [CW-1:0]     cnt_r;
    logic [PW-1:0]     y_r;

    logic              accept_s;
    logic              last_step_s;
    logic [WIDTH-1:0]  a_mag_s;
    logic [WIDTH-1:0]  b_mag_s;
    logic [PW-1:0]     addend_s;
    logic [PW-1:0]     sum_s;
    logic              carry_s;
    logic [PW-1:0]     prod_step_s;
    logic              shifted_out_unused_s;

    assign accept_s    = (state_r == IDLE) && in_valid;
    assign last_step_s = (cnt_r == CNT_ONE);

    // Operand magnitudes; the most negative value maps onto its unsigned twin.
    always_comb begin
        if (signed_mode && a[WIDTH-1]) begin
            a_mag_s = negate_w(a);
        end else begin
            a_mag_s = a;
        end
        if (signed_mode && b[WIDTH-1]) begin
            b_mag_s = negate_w(b);
        end else begin
            b_mag_s = b;
        end
    end

    // The multiplier magnitude lives in the low half of prod_r; its LSB picks the addend.
    always_comb begin
        if (prod_r[0]) begin
            addend_s = {mag_a_r, {WIDTH{1'b0}}};
        end else begin
            addend_s = {PW{1'b0}};
        end
    end

    adder_nbit #(
        .N(PW)
    ) u_acc (
        .a    (prod_r),
        .b    (addend_s),
        .cin  (1'b0),
        .sum  (sum_s),
        .cout (carry_s)
    );

    // The carry re-enters at the top; bit 0 is the multiplier bit just consumed.
    assign prod_step_s          = {carry_s, sum_s[PW-1:1]};
    assign shifted_out_unused_s = sum_s[0];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (last_step_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Operand capture, shift-and-add iteration and result load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mag_a_r <= {WIDTH{1'b0}};
            prod_r  <= {PW{1'b0}};
            neg_r   <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            y_r     <= {PW{1'b0}};
        end else if (accept_s) begin
            mag_a_r <= a_mag_s;
            prod_r  <= {{WIDTH{1'b0}}, b_mag_s};
            neg_r   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt_r   <= CNT_LOAD;
        end else if (state_r == CALC) begin
            prod_r <= prod_step_s;
            cnt_r  <= cnt_r - CNT_ONE;
            if (last_step_s) begin
                y_r <= neg_r ? negate_p(prod_step_s) : prod_step_s;
            end else begin
                y_r <= y_r;
            end
        end else begin
            prod_r <= prod_r;
            cnt_r  <= cnt_r;
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign y         = y_r;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and randomized checks of seq_multiplier at WIDTH=4 and WIDTH=8.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid4, in_ready4, sm4, out_valid4, out_ready4;
    logic [3:0]  a4, b4;
    logic [7:0]  y4;

    logic        in_valid8, in_ready8, sm8, out_valid8, out_ready8;
    logic [7:0]  a8, b8;
    logic [15:0] y8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .signed_mode(sm4), .out_valid(out_valid4),
        .out_ready(out_ready4), .y(y4)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .signed_mode(sm8), .out_valid(out_valid8),
        .out_ready(out_ready8), .y(y8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one operand pair to the WIDTH=4 instance and checks latency and product.
    task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic sm,
                        input logic [7:0] exp, input string tag);
        int cyc;
        cyc = 0;
        while (!in_ready4 && cyc < 50) begin
            tick();
            cyc++;
        end
        check({tag, " in_ready"}, 64'(in_ready4), 64'd1);
        a4 = av; b4 = bv; sm4 = sm; in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        cyc = 0;
        while (!out_valid4 && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'd4);
        check({tag, " y"}, 64'(y4), 64'(exp));
    endtask

    initial begin
        logic [7:0]  ra, rb;
        logic        rs;
        logic [15:0] exp8;
        int          cyc;
        int          hold;

        rst_n = 1'b0;
        in_valid4 = 1'b0; a4 = 4'd0; b4 = 4'd0; sm4 = 1'b0; out_ready4 = 1'b1;
        in_valid8 = 1'b0; a8 = 8'd0; b8 = 8'd0; sm8 = 1'b0; out_ready8 = 1'b1;
        tick();
        tick();
        check("reset out_valid", 64'(out_valid4), 64'd0);
        check("reset y", 64'(y4), 64'd0);
        rst_n = 1'b1;
        tick();
        check("reset in_ready", 64'(in_ready4), 64'd1);

        run4(4'd15, 4'd15, 1'b0, 8'hE1, "u15x15");
        run4(4'h8, 4'h8, 1'b1, 8'h40, "s-8x-8");
        run4(4'hD, 4'h5, 1'b1, 8'hF1, "s-3x5");
        run4(4'h0, 4'h9, 1'b1, 8'h00, "s0x-7");
        run4(4'hD, 4'h5, 1'b0, 8'h41, "u13x5");

        // Backpressure: hold the product for 10 cycles.
        tick();
        out_ready4 = 1'b0;
        run4(4'd6, 4'd7, 1'b0, 8'h2A, "bp");
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp y held", 64'(y4), 64'h2A);
            check("bp out_valid held", 64'(out_valid4), 64'd1);
            check("bp in_ready low", 64'(in_ready4), 64'd0);
        end
        out_ready4 = 1'b1;
        check("bp release cycle in_ready", 64'(in_ready4), 64'd0);
        tick();
        check("bp idle out_valid", 64'(out_valid4), 64'd0);
        check("bp idle in_ready", 64'(in_ready4), 64'd1);

        // Operands change while the first pair is being multiplied.
        a4 = 4'd3; b4 = 4'd5; sm4 = 1'b0; in_valid4 = 1'b1;
        tick();
        a4 = 4'd15; b4 = 4'd15;
        cyc = 0;
        while (!out_valid4 && cyc < 20) begin
            check("chg in_ready low", 64'(in_ready4), 64'd0);
            tick();
            cyc++;
        end
        check("chg latency", 64'(cyc), 64'd4);
        check("chg y", 64'(y4), 64'h0F);
        tick();
        check("chg idle in_ready", 64'(in_ready4), 64'd1);
        tick();
        in_valid4 = 1'b0;
        check("chg second accepted", 64'(in_ready4), 64'd0);
        cyc = 0;
        while (!out_valid4 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("chg second latency", 64'(cyc), 64'd4);
        check("chg second y", 64'(y4), 64'hE1);
        tick();

        // Reset during CALC aborts the transaction.
        a4 = 4'd9; b4 = 4'd9; sm4 = 1'b0; in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("rstmid out_valid", 64'(out_valid4), 64'd0);
        check("rstmid y", 64'(y4), 64'd0);
        check("rstmid in_ready", 64'(in_ready4), 64'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rstmid no output", 64'(out_valid4), 64'd0);
        end
        check("rstmid in_ready after", 64'(in_ready4), 64'd1);
        run4(4'd2, 4'd3, 1'b0, 8'h06, "post-rst");
        tick();

        // Randomized sweep on the WIDTH=8 instance against a reference product.
        for (int n = 0; n < 60; n++) begin
            if (n == 0) begin
                ra = 8'h80; rb = 8'h80; rs = 1'b1;
            end else if (n == 1) begin
                ra = 8'hFF; rb = 8'hFF; rs = 1'b0;
            end else if (n == 2) begin
                ra = 8'h00; rb = 8'h80; rs = 1'b1;
            end else begin
                ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom_range(0, 1));
            end
            if (rs) begin
                exp8 = $signed({{8{ra[7]}}, ra}) * $signed({{8{rb[7]}}, rb});
            end else begin
                exp8 = {8'h00, ra} * {8'h00, rb};
            end
            cyc = 0;
            while (!in_ready8 && cyc < 50) begin
                tick();
                cyc++;
            end
            check("w8 in_ready", 64'(in_ready8), 64'd1);
            a8 = ra; b8 = rb; sm8 = rs; in_valid8 = 1'b1;
            tick();
            in_valid8 = 1'b0;
            cyc = 0;
            while (!out_valid8 && cyc < 30) begin
                out_ready8 = 1'($urandom_range(0, 1));
                tick();
                cyc++;
            end
            check("w8 latency", 64'(cyc), 64'd8);
            check("w8 y", 64'(y8), 64'(exp8));
            hold = $urandom_range(0, 3);
            out_ready8 = 1'b0;
            for (int h = 0; h < hold; h++) begin
                tick();
                check("w8 hold valid", 64'(out_valid8), 64'd1);
                check("w8 hold y", 64'(y8), 64'(exp8));
            end
            out_ready8 = 1'b1;
            tick();
            check("w8 release", 64'(out_valid8), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits (legal 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  WIDTH  multiplicand.
REQ-007 SHALL have port b  input  WIDTH  multiplier.
REQ-008 SHALL have port signed_mode  input  1  1 = two's-complement operands and product, 0 = unsigned.
REQ-009 SHALL have port out_valid  output  1  product available.
REQ-010 SHALL have port out_ready  input  1  consumer takes product.
REQ-011 SHALL have port y  output  2*WIDTH  product.

Function
REQ-012 SHALL implement states IDLE, CALC, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-013 SHALL accept operands on a rising edge with in_valid & in_ready, capturing a, b, signed_mode and entering CALC.
REQ-014 SHALL, on accept, store |a| and |b| (magnitudes when signed_mode=1, raw values otherwise) and result sign = a[MSB]^b[MSB] when signed_mode=1, else 0.
REQ-015 SHALL in CALC perform one shift-and-add step per cycle (add shifted magnitude of a when current bit of |b| is 1), WIDTH steps total, tracked by a down-counter.
REQ-016 SHALL on the WIDTH-th CALC edge load y with the 2*WIDTH-bit product, two's-complement negated if the result sign is 1, and enter DONE; accept-to-out_valid latency is exactly WIDTH cycles.
REQ-017 SHALL hold y and out_valid stable in DONE while out_ready=0 (unbounded backpressure).
REQ-018 SHALL return DONE->IDLE on an edge with out_ready=1; in_ready is not asserted in that same cycle (one bubble cycle between transactions).
REQ-019 SHALL ignore in_valid, a, b and signed_mode outside IDLE; captured values are unaffected by input changes mid-operation.
REQ-020 SHALL hold y at its last value in IDLE and CALC; y is only valid while out_valid=1.
REQ-021 SHALL produce a correct result for signed -2^(WIDTH-1) x -2^(WIDTH-1) (positive 2^(2*WIDTH-2)) and for any zero operand (y=0, no negative zero issue).
REQ-022 SHALL never overflow: internal accumulator is 2*WIDTH bits, magnitude registers WIDTH bits (|-2^(WIDTH-1)| fits unsigned).

Reset
REQ-023 SHALL on rst_n=0 at a rising edge force state IDLE, counter 0, y=0, in_ready=1 after release, out_valid=0.
REQ-024 SHALL abort any in-flight CALC or DONE transaction on reset with no output produced.
REQ-025 SHALL give reset priority over all handshake events in the same cycle.

Structure
REQ-026 SHALL place the state enum (IDLE, CALC, DONE) and a function for counter width ($clog2(WIDTH)+1) in shared package seq_mult_pkg.
REQ-027 SHALL use one sub-module, adder_nbit (parametrised ripple adder, width 2*WIDTH, carry-in, carry-out), for the accumulate step; all control stays in seq_multiplier.

Verification
REQ-028 SHALL test WIDTH=4 unsigned a=15, b=15, out_ready=1 -> out_valid exactly 4 cycles after accept, y=8'hE1 (225).
REQ-029 SHALL test WIDTH=4 signed a=-8, b=-8 -> y=8'h40 (64); a=-3, b=5 -> y=8'hF1 (-15); a=0, b=-7 -> y=8'h00.
REQ-030 SHALL test backpressure: a=6, b=7 unsigned, out_ready=0 for 10 cycles -> y=8'h2A held, out_valid=1, in_ready=0 throughout; out_ready=1 -> IDLE next edge, in_ready=1 one cycle later.
REQ-031 SHALL test operand change during CALC: accept a=3, b=5, then drive a=15, b=15, in_valid=1 -> y=8'h0F, second pair not accepted until in_ready=1.
REQ-032 SHALL test reset mid-CALC: accept a=9, b=9, assert rst_n=0 at cycle 2 -> out_valid never asserts, y=0, in_ready=1 after release; next transaction a=2, b=3 -> y=8'h06.
REQ-033 SHALL run a randomized sweep at WIDTH=8 (both modes, random out_ready) against a reference model, all products exact.
